// File: rtl/vga_scanner_if.sv
// vga_scanner_if: framebuffer read port plus the VGA video outputs of the scanner.
// master = scanner side, slave = vga_ram / display side.
interface vga_scanner_if;
   logic [31:0] vga_pixel_addr;
   logic [7:0]  vga_pixel_val;
   logic [7:0]  vga_r;
   logic [7:0]  vga_g;
   logic [7:0]  vga_b;
   logic        vga_hs;
   logic        vga_vs;
   logic        vga_blank_n;
   logic        frame_start;

   modport master (
      output vga_pixel_addr,
      input  vga_pixel_val,
      output vga_r,
      output vga_g,
      output vga_b,
      output vga_hs,
      output vga_vs,
      output vga_blank_n,
      output frame_start
   );

   modport slave (
      input  vga_pixel_addr,
      output vga_pixel_val,
      input  vga_r,
      input  vga_g,
      input  vga_b,
      input  vga_hs,
      input  vga_vs,
      input  vga_blank_n,
      input  frame_start
   );
endinterface

// File: rtl/vga_scanner.sv
// vga_scanner: 640x480@60 VGA timing on clk_vga, framebuffer reads one pixel
// ahead of the beam, and RGB332 -> 8:8:8 expansion with aligned sync/blank.
// Three register stages: p0 (address + flags), p1 (memory returns data),
// p2 (colour + outputs). All outputs move on the same edge.
// Optional build macro VGA_SCANNER_SCALE2_EN: 2x2 pixel doubling of the image.
module vga_scanner #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int IMG_W    = 256,
   parameter int IMG_H    = 256,
`ifdef VGA_SCANNER_SCALE2_EN
   parameter int X_OFF    = 64,
   parameter int Y_OFF    = 0,
`else
   parameter int X_OFF    = 192,
   parameter int Y_OFF    = 112,
`endif
   parameter logic [7:0] BG = 8'h00
) (
   input  logic          clk_vga,
   input  logic          reset,
   vga_scanner_if.master vga
);

   // Pixel format is RGB332; the expansion below is written for exactly 8 bits.
   localparam int DATA_W = 8;

`ifdef VGA_SCANNER_SCALE2_EN
   localparam int SCALE_SH = 1;
`else
   localparam int SCALE_SH = 0;
`endif

   localparam int W_EFF   = IMG_W << SCALE_SH;
   localparam int H_EFF   = IMG_H << SCALE_SH;
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
   localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
   localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

   // Bit-replicating RGB332 -> 8:8:8 so full-scale codes reach 8'hFF.
   function automatic logic [23:0] expand332(input logic [DATA_W-1:0] p);
      return {p[7:5], p[7:5], p[7:6],
              p[4:2], p[4:2], p[4:3],
              {4{p[1:0]}}};
   endfunction

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;

   // Counter-stage decode (combinational from h_cnt/v_cnt)
   logic signed [31:0] dx;
   logic signed [31:0] dy;
   logic               in_active;
   logic               in_image;
   logic [31:0]        rd_addr;
   logic               hs_n;
   logic               vs_n;
   logic               frame_org;

   logic [31:0] addr_p0;
   logic        hit_p0, vld_p0, hs_p0, vs_p0, fs_p0;
   logic        hit_p1, vld_p1, hs_p1, vs_p1, fs_p1;
   logic [23:0] rgb_p2;
   logic        vld_p2, hs_p2, vs_p2, fs_p2;

   // Beam position: h wraps every line, v advances on h wrap and wraps per frame.
   always_ff @(posedge clk_vga or negedge reset) begin
      if (!reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
         h_cnt <= h_cnt + HW'(1);
      end
   end

   // Decode region, image hit, read address and sync windows for the current position.
   always_comb begin
      dx        = $signed(32'(h_cnt)) - X_OFF;
      dy        = $signed(32'(v_cnt)) - Y_OFF;
      in_active = (h_cnt < H_ACT_L) && (v_cnt < V_ACT_L);
      in_image  = in_active && (dx >= 0) && (dx < W_EFF) && (dy >= 0) && (dy < H_EFF);
      rd_addr   = '0;
      if (in_image)
         rd_addr = $unsigned((dy >>> SCALE_SH) * IMG_W + (dx >>> SCALE_SH));
      hs_n      = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
      vs_n      = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
      frame_org = (h_cnt == '0) && (v_cnt == '0);
   end

   // Stage p0: issue the read address; flags start their trip alongside it.
   always_ff @(posedge clk_vga or negedge reset) begin
      if (!reset) begin
         addr_p0 <= '0;
         hit_p0  <= 1'b0;
         vld_p0  <= 1'b0;
         hs_p0   <= 1'b1;
         vs_p0   <= 1'b1;
         fs_p0   <= 1'b0;
      end else begin
         addr_p0 <= rd_addr;
         hit_p0  <= in_image;
         vld_p0  <= in_active;
         hs_p0   <= hs_n;
         vs_p0   <= vs_n;
         fs_p0   <= frame_org;
      end
   end

   // Stage p1: memory turns the address around; flags wait one cycle with it.
   always_ff @(posedge clk_vga or negedge reset) begin
      if (!reset) begin
         hit_p1 <= 1'b0;
         vld_p1 <= 1'b0;
         hs_p1  <= 1'b1;
         vs_p1  <= 1'b1;
         fs_p1  <= 1'b0;
      end else begin
         hit_p1 <= hit_p0;
         vld_p1 <= vld_p0;
         hs_p1  <= hs_p0;
         vs_p1  <= vs_p0;
         fs_p1  <= fs_p0;
      end
   end

   // Stage p2: pick image pixel, background or black, and register every output together.
   always_ff @(posedge clk_vga or negedge reset) begin
      if (!reset) begin
         rgb_p2 <= '0;
         vld_p2 <= 1'b0;
         hs_p2  <= 1'b1;
         vs_p2  <= 1'b1;
         fs_p2  <= 1'b0;
      end else begin
         if (hit_p1)
            rgb_p2 <= expand332(vga.vga_pixel_val);
         else if (vld_p1)
            rgb_p2 <= expand332(BG);
         else
            rgb_p2 <= '0;
         vld_p2 <= vld_p1;
         hs_p2  <= hs_p1;
         vs_p2  <= vs_p1;
         fs_p2  <= fs_p1;
      end
   end

   assign vga.vga_pixel_addr = addr_p0;
   assign vga.vga_r          = rgb_p2[23:16];
   assign vga.vga_g          = rgb_p2[15:8];
   assign vga.vga_b          = rgb_p2[7:0];
   assign vga.vga_hs         = hs_p2;
   assign vga.vga_vs         = vs_p2;
   assign vga.vga_blank_n    = vld_p2;
   assign vga.frame_start    = fs_p2;

endmodule

// File: tb/tb_vga_scanner.sv
// tb_vga_scanner: directed bench for vga_scanner. A short vertical frame
// (19 lines, 4-line image) keeps run time low; horizontal timing is the real
// 800-pixel line. A behavioural model derives every output from the cycle
// count since reset release; literal checks pin the model on key points.
module tb_vga_scanner;
   localparam int HT  = 800;
   localparam int VA  = 12;
   localparam int VFP = 2;
   localparam int VS  = 2;
   localparam int VBP = 3;
   localparam int VT  = VA + VFP + VS + VBP;
   localparam int IW  = 256;
   localparam int IH  = 4;
`ifdef VGA_SCANNER_SCALE2_EN
   localparam int XO = 64;
   localparam int YO = 0;
   localparam int SC = 2;
`else
   localparam int XO = 192;
   localparam int YO = 2;
   localparam int SC = 1;
`endif
   localparam logic [7:0]  BGC     = 8'h1C;
   localparam logic [59:0] RST_VEC = {32'h0, 24'h0, 4'b1100};

   logic clk = 1'b0;
   logic reset;
   logic running = 1'b0;
   int   t;
   int   n_pass  = 0;
   int   n_total = 0;
   logic [59:0] dut_vec;

   always #5 clk = ~clk;

   vga_scanner_if vif();

   vga_scanner #(
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .IMG_H(IH), .X_OFF(XO), .Y_OFF(YO), .BG(BGC)
   ) dut (
      .clk_vga(clk),
      .reset  (reset),
      .vga    (vif)
   );

   assign dut_vec = {vif.vga_pixel_addr, vif.vga_r, vif.vga_g, vif.vga_b,
                     vif.vga_hs, vif.vga_vs, vif.vga_blank_n, vif.frame_start};

   // Framebuffer contents; address 0 holds magenta (E3).
   function automatic logic [7:0] mem_f(input logic [31:0] a);
      if (a == 32'h0) return 8'hE3;
      return 8'(a * 37 + 11);
   endfunction

   // One-cycle synchronous read port, as vga_ram provides.
   always @(posedge clk) vif.vga_pixel_val <= mem_f(vif.vga_pixel_addr);

   // Rising edges since reset release.
   always @(posedge clk or negedge reset) begin
      if (!reset) t <= 0;
      else        t <= t + 1;
   end

   // Channel scaling to full range: round(x * 255 / max).
   function automatic logic [23:0] rgb_of(input logic [7:0] p);
      int r3, g3, b2;
      r3 = int'(p[7:5]);
      g3 = int'(p[4:2]);
      b2 = int'(p[1:0]);
      return {8'((r3 * 255 + 3) / 7), 8'((g3 * 255 + 3) / 7), 8'(b2 * 85)};
   endfunction

   // Framebuffer index for a screen pixel, or -1 outside the image.
   function automatic int img_addr(input int h, input int v);
      int dx, dy;
      dx = h - XO;
      dy = v - YO;
      if (h >= 640 || v >= VA) return -1;
      if (dx < 0 || dy < 0 || dx >= SC * IW || dy >= SC * IH) return -1;
      return (dy / SC) * IW + dx / SC;
   endfunction

   // Expected {addr, r, g, b, hs, vs, blank_n, frame_start} after edge tt.
   function automatic logic [59:0] model(input int tt);
      int n, h, v, a, ia;
      logic [23:0] rgb;
      logic hs, vs, bl, fs;
      a = 0;
      if (tt >= 1) begin
         n  = tt - 1;
         ia = img_addr(n % HT, (n / HT) % VT);
         if (ia >= 0) a = ia;
      end
      if (tt < 3) return {32'(a), 24'h0, 4'b1100};
      n  = tt - 3;
      h  = n % HT;
      v  = (n / HT) % VT;
      bl = (h < 640) && (v < VA);
      hs = !(h >= 656 && h < 656 + 96);
      vs = !(v >= VA + VFP && v < VA + VFP + VS);
      fs = (h == 0) && (v == 0);
      ia = img_addr(h, v);
      if (ia >= 0)  rgb = rgb_of(mem_f(32'(ia)));
      else if (bl)  rgb = rgb_of(BGC);
      else          rgb = 24'h0;
      return {32'(a), rgb, hs, vs, bl, fs};
   endfunction

   task automatic finish_run;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else begin
         $display("FAIL %s at t=%0d: got %0h required %0h", name, t, act, exp);
         if (n_total - n_pass > 200) finish_run();
      end
   endtask

   task automatic goto(input int n);
      int guard;
      guard = 0;
      while (t < n && guard < 100000) begin
         @(negedge clk);
         guard++;
      end
      if (t != n) begin
         n_total++;
         $display("FAIL goto: t=%0d required %0d", t, n);
      end
   endtask

   // Model comparison on every falling edge.
   always @(negedge clk) begin
      if (running) chk("model", 64'(dut_vec), 64'(model(t)));
   end

   initial begin
      #1_000_000;
      n_total++;
      $display("FAIL watchdog: simulation time limit reached at t=%0d", t);
      finish_run();
   end

   initial begin
      int cnt_bl, cnt_hs, cnt_vs, cnt_fs;
      reset = 1'b1;
      #1 reset = 1'b0;
      running = 1'b1;
      #1 chk("reset_vec", 64'(dut_vec), 64'(RST_VEC));
      repeat (4) @(negedge clk);
      reset = 1'b1;

      // Frame start three edges after release
      goto(2);
      chk("fs_t2", 64'(vif.frame_start), 64'd0);
      goto(3);
      chk("fs_t3", 64'(vif.frame_start), 64'd1);
      chk("bg_rgb", 64'({vif.vga_r, vif.vga_g, vif.vga_b}), 64'h00FF00);

      // First line: blank and hsync widths, hsync edge, blanking colour
      cnt_bl = 0;
      cnt_hs = 0;
      for (int i = 0; i < HT; i++) begin
         cnt_bl += int'(vif.vga_blank_n);
         cnt_hs += int'(!vif.vga_hs);
         if (t == 4)   chk("fs_t4", 64'(vif.frame_start), 64'd0);
         if (t == 658) chk("hs_before", 64'(vif.vga_hs), 64'd1);
         if (t == 659) chk("hs_fall", 64'(vif.vga_hs), 64'd0);
         if (t == 703) chk("blank_rgb", 64'({vif.vga_r, vif.vga_g, vif.vga_b, vif.vga_blank_n}), 64'h0);
         @(negedge clk);
      end
      chk("blank_per_line", 64'(cnt_bl), 64'd640);
      chk("hs_low_per_line", 64'(cnt_hs), 64'd96);

`ifdef VGA_SCANNER_SCALE2_EN
      goto(65);         chk("addr_64_0", 64'(vif.vga_pixel_addr), 64'd0);
      goto(66);         chk("addr_65_0", 64'(vif.vga_pixel_addr), 64'd0);
                        chk("rgb_63_0", 64'({vif.vga_r, vif.vga_g, vif.vga_b}), 64'h00FF00);
      goto(67);         chk("rgb_64_0", 64'({vif.vga_r, vif.vga_g, vif.vga_b}), 64'hFF00FF);
      goto(HT + 65);    chk("addr_64_1", 64'(vif.vga_pixel_addr), 64'd0);
      goto(HT + 66);    chk("addr_65_1", 64'(vif.vga_pixel_addr), 64'd0);
      goto(2 * HT + 67); chk("addr_66_2", 64'(vif.vga_pixel_addr), 64'd257);
`else
      goto(YO * HT + 192);       chk("addr_191", 64'(vif.vga_pixel_addr), 64'd0);
      goto(YO * HT + 193);       chk("addr_192", 64'(vif.vga_pixel_addr), 64'd0);
      goto(YO * HT + 194);       chk("addr_193", 64'(vif.vga_pixel_addr), 64'd1);
                                 chk("rgb_191", 64'({vif.vga_r, vif.vga_g, vif.vga_b}), 64'h00FF00);
      goto(YO * HT + 195);       chk("rgb_192", 64'({vif.vga_r, vif.vga_g, vif.vga_b}), 64'hFF00FF);
      goto((YO + 1) * HT + 448); chk("addr_447", 64'(vif.vga_pixel_addr), 64'd511);
      goto((YO + 1) * HT + 449); chk("addr_448", 64'(vif.vga_pixel_addr), 64'd0);
`endif

      // Vertical sync start
      goto((VA + VFP) * HT + 2); chk("vs_before", 64'(vif.vga_vs), 64'd1);
      goto((VA + VFP) * HT + 3); chk("vs_fall", 64'(vif.vga_vs), 64'd0);

      // Second frame: one frame_start per 800*VT cycles, vsync width
      goto(VT * HT + 3);
      chk("fs_frame2", 64'(vif.frame_start), 64'd1);
      cnt_vs = 0;
      cnt_fs = 0;
      for (int i = 0; i < VT * HT; i++) begin
         cnt_vs += int'(!vif.vga_vs);
         cnt_fs += int'(vif.frame_start);
         @(negedge clk);
      end
      chk("vs_low_per_frame", 64'(cnt_vs), 64'(VS * HT));
      chk("fs_per_frame", 64'(cnt_fs), 64'd1);
      chk("fs_frame3", 64'(vif.frame_start), 64'd1);

      // Asynchronous reset in the middle of a line
      goto(2 * VT * HT + 3 + 5 * HT + 300);
      @(posedge clk);
      #3 reset = 1'b0;
      #1 chk("async_reset", 64'(dut_vec), 64'(RST_VEC));
      repeat (3) @(negedge clk);
      chk("reset_hold", 64'(dut_vec), 64'(RST_VEC));
      reset = 1'b1;
      goto(2);
      chk("refs_t2", 64'(vif.frame_start), 64'd0);
      goto(3);
      chk("refs_t3", 64'(vif.frame_start), 64'd1);
      goto(4);
      chk("refs_t4", 64'(vif.frame_start), 64'd0);
      goto(900);
      finish_run();
   end
endmodule
